// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, addresses the instruction ROM and
// buffers returned words in a small FIFO presented to decode via valid/ready.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          DATA_WIDTH = 32,
    parameter int          DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_en,
    output logic [31:0]           rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [31:0]           instr_pc
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    // Handshake: a word transfers to decode on any cycle where
    // instr_valid and instr_ready are both high; instr_valid never depends on instr_ready.
    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } fill_state_t;

    fill_state_t fill_state;

    logic [31:0]           pc, pc_next;
    logic [CW-1:0]         count, count_next;
    logic [AW-1:0]         rd_ptr, rd_ptr_next;
    logic [AW-1:0]         wr_ptr, wr_ptr_next;
    logic [DATA_WIDTH-1:0] buf_data [DEPTH];
    logic [31:0]           buf_pc   [DEPTH];
    logic                  pop, push;

    // Fill state is a pure decode of the registered occupancy count.
    always_comb begin
        fill_state = PARTIAL;
        if (count == '0)
            fill_state = EMPTY;
        else if (count == CW'(DEPTH))
            fill_state = FULL;
    end

    assign instr_valid = (fill_state != EMPTY);
    assign instr       = buf_data[rd_ptr];
    assign instr_pc    = buf_pc[rd_ptr];
    assign rom_addr    = pc;

    assign pop  = instr_valid & instr_ready;
    assign push = fetch_en & ~redirect_valid & ((fill_state != FULL) | pop);

    always_comb begin
        pc_next     = pc;
        count_next  = count;
        rd_ptr_next = rd_ptr;
        wr_ptr_next = wr_ptr;
        if (redirect_valid) begin
            // A redirect squashes everything in flight, including this cycle's pop.
            pc_next     = redirect_pc;
            count_next  = '0;
            rd_ptr_next = '0;
            wr_ptr_next = '0;
        end else begin
            if (push) begin
                pc_next     = pc + 32'd1;
                wr_ptr_next = wr_ptr + AW'(1);
            end
            if (pop)
                rd_ptr_next = rd_ptr + AW'(1);
            if (push && !pop)
                count_next = count + CW'(1);
            else if (pop && !push)
                count_next = count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc     <= RESET_PC;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_data[i] <= '0;
                buf_pc[i]   <= '0;
            end
        end else begin
            pc     <= pc_next;
            count  <= count_next;
            rd_ptr <= rd_ptr_next;
            wr_ptr <= wr_ptr_next;
            if (push) begin
                buf_data[wr_ptr] <= rom_data;
                buf_pc[wr_ptr]   <= pc;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: two instances (RESET_PC 0 and 0xFFFFFFFF)
// share stimulus; each ROM returns 0xA0000000 + address.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_ready;

    logic [31:0] rom_addr, rom_data, instr, instr_pc;
    logic        instr_valid;
    logic [31:0] w_rom_addr, w_rom_data, w_instr, w_instr_pc;
    logic        w_instr_valid;

    int n_checks = 0;
    int n_fails  = 0;

    assign rom_data   = 32'hA000_0000 + rom_addr;
    assign w_rom_data = 32'hA000_0000 + w_rom_addr;

    fetch_unit #(.RESET_PC(32'h0000_0000), .DATA_WIDTH(32), .DEPTH(2)) dut (
        .clk(clk), .rst(rst), .fetch_en(fetch_en),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFF), .DATA_WIDTH(32), .DEPTH(2)) dut_w (
        .clk(clk), .rst(rst), .fetch_en(fetch_en),
        .rom_addr(w_rom_addr), .rom_data(w_rom_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(w_instr_valid), .instr_ready(instr_ready),
        .instr(w_instr), .instr_pc(w_instr_pc)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fails++;
            $display("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // advance one edge; outputs are sampled 1 time unit later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic ready);
        rst            = 1'b1;
        fetch_en       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = ready;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0;
        redirect_pc = '0; instr_ready = 1'b0;

        // 1 + 5: reset state, then streaming at 1/cycle; wrap on the second instance
        do_reset(1'b1);
        check("t1_rst_rom_addr",   rom_addr,      32'h0);
        check("t1_rst_valid",      {31'b0, instr_valid}, 32'd0);
        check("t1_rst_instr",      instr,         32'h0);
        check("t1_rst_instr_pc",   instr_pc,      32'h0);
        check("t5_rst_rom_addr",   w_rom_addr,    32'hFFFF_FFFF);
        check("t5_rst_valid",      {31'b0, w_instr_valid}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t1_valid",      {31'b0, instr_valid}, 32'd1);
            check("t1_instr_pc",   instr_pc,      32'(i));
            check("t1_instr",      instr,         32'hA000_0000 + 32'(i));
            check("t5_instr_pc",   w_instr_pc,    32'hFFFF_FFFF + 32'(i));
            check("t5_instr",      w_instr,       32'h9FFF_FFFF + 32'(i));
        end

        // 2: backpressure fills the buffer, PC holds, then drains in order
        do_reset(1'b0);
        tick(); tick(); tick();
        check("t2_full_rom_addr",  rom_addr,      32'h2);
        check("t2_full_count",     32'(dut.count), 32'd2);
        check("t2_full_head_pc",   instr_pc,      32'h0);
        instr_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            tick();
            check("t2_drain_valid", {31'b0, instr_valid}, 32'd1);
            check("t2_drain_pc",    instr_pc,     32'(i));
            check("t2_drain_instr", instr,        32'hA000_0000 + 32'(i));
        end

        // 3: redirect while full
        do_reset(1'b0);
        tick(); tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        tick();
        check("t3_redir_valid",    {31'b0, instr_valid}, 32'd0);
        check("t3_redir_rom_addr", rom_addr,      32'h40);
        redirect_valid = 1'b0;
        instr_ready    = 1'b1;
        tick();
        check("t3_target_valid",   {31'b0, instr_valid}, 32'd1);
        check("t3_target_pc",      instr_pc,      32'h40);
        check("t3_target_instr",   instr,         32'hA000_0040);

        // 4: simultaneous push and pop at full keeps count at 2
        do_reset(1'b0);
        tick(); tick();
        instr_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            tick();
            check("t4_count",      32'(dut.count), 32'd2);
            check("t4_pc",         instr_pc,      32'(i));
            check("t4_rom_addr",   rom_addr,      32'(i + 2));
        end

        // 6: fetch_en low freezes PC, then reset with redirect mid-stream
        do_reset(1'b0);
        tick(); tick();
        instr_ready = 1'b1;
        tick();
        fetch_en = 1'b0;
        tick();
        check("t6_frozen_rom_addr", rom_addr,     32'h3);
        check("t6_drain_count",     32'(dut.count), 32'd1);
        check("t6_drain_pc",        instr_pc,     32'h2);
        rst            = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        tick();
        check("t6_rst_valid",      {31'b0, instr_valid}, 32'd0);
        check("t6_rst_rom_addr",   rom_addr,      32'h0);
        check("t6_rst_instr",      instr,         32'h0);
        check("t6_rst_instr_pc",   instr_pc,      32'h0);
        check("t6_rst_w_rom_addr", w_rom_addr,    32'hFFFF_FFFF);
        rst            = 1'b0;
        redirect_valid = 1'b0;
        tick();
        check("t6_post_rom_addr",  rom_addr,      32'h0);
        check("t6_post_valid",     {31'b0, instr_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of the instruction ROM and feeds decode. It holds the program counter, drives the ROM word address, and captures the combinationally returned instruction word into a small FIFO buffer. It presents instructions to decode over a valid/ready handshake, and supports fetch enable, backpressure and branch/jump redirect with buffer flush.

Parameters:
RESET_PC, 32'h0000_0000, word address loaded into PC on reset
DATA_WIDTH, 32, instruction word width; must match the ROM data width
DEPTH, 2, instruction buffer entries (power of two, >= 2)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
fetch_en  input  1  permits fetching; when low, PC holds and no push occurs
rom_addr  output  32  word address to the ROM; combinational copy of PC register
rom_data  input  DATA_WIDTH  instruction word from the ROM for rom_addr, valid in the same cycle
redirect_valid  input  1  branch/jump taken; flush buffer and load PC
redirect_pc  input  32  word address target for redirect
instr_valid  output  1  buffer head holds a valid instruction
instr_ready  input  1  decode accepts the head this cycle
instr  output  DATA_WIDTH  instruction at buffer head
instr_pc  output  32  word address of instr

Behaviour:
- Addressing: PC is a word address. The increment is +1 and wraps mod 2^32 (32'hFFFF_FFFF -> 0). The ROM masks upper bits itself; this block does not.
- Reset (rst=1 at a clock edge):
  - pc=RESET_PC, count=0, read/write pointers=0.
  - instr_valid=0, instr=0, instr_pc=0.
  - rom_addr=RESET_PC in the cycle after reset.
  - Reset mid-operation discards all buffered entries and overrides redirect.
- Definitions:
  - pop = instr_valid & instr_ready.
  - push = fetch_en & ~redirect_valid & (count<DEPTH | pop).
- Push: write {rom_data, pc} into the tail entry, then pc <= pc+1. With no push, pc holds.
- Pop: advance the head pointer. The head entry is not cleared.
- Simultaneous push and pop are allowed, including when full (count unchanged). Pop when empty is impossible since instr_valid=0.
- count updates: +1 on push-only, -1 on pop-only, unchanged on both or neither. It never exceeds DEPTH or goes below 0.
- instr_valid = (count != 0), registered state. instr and instr_pc are the head entry, driven from registered storage with no combinational path from rom_data.
- Latency: a word pushed at edge N is visible on instr/instr_valid in cycle N+1 if the buffer was empty. Sustained throughput is 1 instruction/cycle with instr_ready=1.
- Redirect (redirect_valid=1 at an edge, highest priority after rst):
  - count=0 and pointers reset, so instr_valid=0 the next cycle.
  - pc <= redirect_pc.
  - No push and no pop take effect that cycle; the instruction accepted by decode in that cycle is considered squashed by decode.
  - First target instruction: rom_addr=redirect_pc at N+1, pushed at N+1, instr_valid=1 with instr_pc=redirect_pc at N+2.
  - Back-to-back redirects: the last one wins.
- fetch_en low: pc and pushes frozen; pops continue and drain the buffer.
- Full with no pop: pc and rom_addr hold steady. The same word is re-read once space frees, so no instruction is lost or duplicated.
- State summary (FSM encoded implicitly by count):
  - EMPTY (count=0): instr_valid=0.
  - PARTIAL: may push and pop.
  - FULL (count=DEPTH): push only with a simultaneous pop.
- Output X-free: instr/instr_pc are zero until the first push.

Test Plan:
1. Reset, ROM mem[i]=32'hA000_0000+i, fetch_en=1, instr_ready=1 -> rom_addr=0 after reset. Pairs (instr_pc,instr) = (0,A0000000),(1,A0000001),(2,A0000002) on consecutive cycles starting 1 cycle after the first push.
2. Backpressure: instr_ready=0 from start -> buffer fills with pc 0,1. rom_addr holds at 2. Raise ready -> outputs 0,1,2,3 in order with no gaps or duplicates.
3. Redirect while full, redirect_pc=32'h40 -> instr_valid=0 next cycle, rom_addr=32'h40. Two cycles after redirect: instr_valid=1, instr_pc=32'h40, instr=mem[0x40].
4. Pop and push in the same cycle at full with ready=1 -> count stays 2 and throughput stays 1/cycle with sequential instr_pc.
5. RESET_PC=32'hFFFF_FFFF -> instr_pc sequence FFFFFFFF, 00000000, 00000001.
6. fetch_en=0 after 3 fetches, then rst asserted mid-stream with redirect_valid=1 -> draining stops. After reset: instr_valid=0, rom_addr=RESET_PC, and the redirect is ignored.
